alu_op_sequencer: RTL

Initiator side of the ALU interface for the multi-cycle MIPS datapath.
- Accepts decoded-instruction requests over a valid/ready handshake.
- Decodes opcode/funct into the 4-bit ALU control code and selects the operands, including immediate extension.
- Drives an external combinational alu_32 instance, then captures its result and zero flag.
- Returns result, branch decision and illegal flag over a valid/ready response handshake.

---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu_op_decoder.sv | 80 ++++++++
 rtl/alu_op_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the ALU operation sequencer: ALU control codes,
// MIPS opcode/funct encodings, FSM state encodings, branch-type and
// immediate-extension enumerations.
// Ports: none (package).
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU control codes understood by the external alu_32
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Instruction opcodes [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes [5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Sequencer FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2
  } branch_e;

  typedef enum logic [1:0] {
    EXT_SIGN = 2'd0,
    EXT_ZERO = 2'd1,
    EXT_NONE = 2'd2
  } ext_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// alu_op_decoder
// ----------------------------------------------------------------------------
// Purely combinational opcode/funct decoder producing the ALU control code,
// operand-1 source, immediate extension, branch type and illegal flag.
// Ports:
//   opcode_i      [5:0]  instruction opcode
//   funct_i       [5:0]  funct field, meaningful for R-type only
//   alu_control_o [3:0]  ALU operation select
//   op1_imm_o            1: operand 1 is the extended immediate, 0: rt
//   ext_o                immediate extension type
//   branch_o             branch type (none / beq / bne)
//   illegal_o            unsupported opcode or funct
// Revision: 1.0 - initial release
// ============================================================================
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       op1_imm_o,
  output ext_e       ext_o,
  output branch_e    branch_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_AND;
    op1_imm_o     = 1'b0;
    ext_o         = EXT_NONE;
    branch_o      = BR_NONE;
    illegal_o     = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_NOR:  alu_control_o = ALU_NOR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: illegal_o     = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        alu_control_o = ALU_ADD;
        op1_imm_o     = 1'b1;
        ext_o         = EXT_SIGN;
      end
      OP_SLTI: begin
        alu_control_o = ALU_SLT;
        op1_imm_o     = 1'b1;
        ext_o         = EXT_SIGN;
      end
      OP_ANDI: begin
        alu_control_o = ALU_AND;
        op1_imm_o     = 1'b1;
        ext_o         = EXT_ZERO;
      end
      OP_ORI: begin
        alu_control_o = ALU_OR;
        op1_imm_o     = 1'b1;
        ext_o         = EXT_ZERO;
      end
      OP_BEQ: begin
        alu_control_o = ALU_SUB;
        branch_o      = BR_BEQ;
      end
      OP_BNE: begin
        alu_control_o = ALU_SUB;
        branch_o      = BR_BNE;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule : alu_op_decoder
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// alu_op_sequencer
// ----------------------------------------------------------------------------
// Initiator side of the ALU interface for the multi-cycle MIPS datapath.
// Accepts a decoded instruction, drives an external combinational ALU for a
// single EXEC cycle, captures its result/zero flag and returns a response.
// Ports:
//   clock, reset                    clock, asynchronous active-high reset
//   req_valid / req_ready           request handshake
//   req_opcode, req_funct           instruction fields for decode
//   req_rs_data, req_rt_data        register operands
//   req_imm                         16-bit immediate
//   resp_valid / resp_ready         response handshake
//   resp_result                     captured ALU result (0 when illegal)
//   resp_branch_taken               beq/bne decision
//   resp_illegal                    unsupported opcode/funct
//   alu_data_in_0/1, alu_control    drive to external ALU
//   alu_result, alu_zero            returned from external ALU
// Revision: 1.0 - initial release
// ============================================================================
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int         DATA_WIDTH       = 32,
  parameter logic [3:0] IDLE_ALU_CONTROL = 4'b0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            req_opcode,
  input  logic [5:0]            req_funct,
  input  logic [DATA_WIDTH-1:0] req_rs_data,
  input  logic [DATA_WIDTH-1:0] req_rt_data,
  input  logic [15:0]           req_imm,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_branch_taken,
  output logic                  resp_illegal,
  output logic [DATA_WIDTH-1:0] alu_data_in_0,
  output logic [DATA_WIDTH-1:0] alu_data_in_1,
  output logic [3:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero
);

  logic [3:0] dec_ctrl;
  logic       dec_op1_imm;
  ext_e       dec_ext;
  branch_e    dec_branch;
  logic       dec_illegal;

  alu_op_decoder u_decoder (
    .opcode_i      (req_opcode),
    .funct_i       (req_funct),
    .alu_control_o (dec_ctrl),
    .op1_imm_o     (dec_op1_imm),
    .ext_o         (dec_ext),
    .branch_o      (dec_branch),
    .illegal_o     (dec_illegal)
  );

  state_t                state_q,   state_d;
  logic [3:0]            ctrl_q,    ctrl_d;
  logic [DATA_WIDTH-1:0] op0_q,     op0_d;
  logic [DATA_WIDTH-1:0] op1_q,     op1_d;
  branch_e               branch_q,  branch_d;
  logic [DATA_WIDTH-1:0] result_q,  result_d;
  logic                  taken_q,   taken_d;
  logic                  illegal_q, illegal_d;

  logic [DATA_WIDTH-1:0] imm_ext;

  always_comb begin
    if (dec_ext == EXT_SIGN) begin
      imm_ext = {{(DATA_WIDTH-16){req_imm[15]}}, req_imm};
    end else begin
      imm_ext = {{(DATA_WIDTH-16){1'b0}}, req_imm};
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    op0_d     = op0_q;
    op1_d     = op1_q;
    branch_d  = branch_q;
    result_d  = result_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ctrl_d    = dec_ctrl;
          op0_d     = req_rs_data;
          op1_d     = dec_op1_imm ? imm_ext : req_rt_data;
          branch_d  = dec_branch;
          // Clearing result/taken here makes an illegal response report zeros
          result_d  = '0;
          taken_d   = 1'b0;
          illegal_d = dec_illegal;
          // Illegal requests never touch the ALU
          state_d   = dec_illegal ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        case (branch_q)
          BR_BEQ:  taken_d = alu_zero;
          BR_BNE:  taken_d = ~alu_zero;
          default: taken_d = 1'b0;
        endcase
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= IDLE_ALU_CONTROL;
      op0_q     <= '0;
      op1_q     <= '0;
      branch_q  <= BR_NONE;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      op0_q     <= op0_d;
      op1_q     <= op1_d;
      branch_q  <= branch_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  logic in_exec;
  assign in_exec = (state_q == ST_EXEC);

  assign req_ready         = (state_q == ST_IDLE);
  assign resp_valid        = (state_q == ST_RESP);
  assign resp_result       = result_q;
  assign resp_branch_taken = taken_q;
  assign resp_illegal      = illegal_q;

  // ALU is only exposed to latched operands during EXEC; quiet otherwise
  assign alu_control   = in_exec ? ctrl_q : IDLE_ALU_CONTROL;
  assign alu_data_in_0 = in_exec ? op0_q  : '0;
  assign alu_data_in_1 = in_exec ? op1_q  : '0;

endmodule : alu_op_sequencer
`default_nettype wire
